// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register feeding the ALU; valid/ready handshake, flush,
// EX/MEM and MEM/WB forwarding, and operand refresh while a held instruction stalls.
// Ports: clk, rst (sync, active-high), flush, id_* decode side (id_valid/id_ready),
// exm_*/mwb_* forwarding sources, ex_* ALU side (ex_valid/ex_ready).
// Optional macro HAZARD_DETECT_EN adds the load-use interlock on id_ready.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module id_ex_stage #(
  parameter int XLEN    = `REG_DATA_WIDTH,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = `ALU_OP_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               id_valid,
  output logic               id_ready,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [RADDR_W-1:0] id_rs1_addr,
  input  logic [RADDR_W-1:0] id_rs2_addr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               id_a_sel,
  input  logic               id_b_sel,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic [RADDR_W-1:0] id_rd_addr,
  input  logic               id_rd_we,
  input  logic               id_is_load,
  input  logic [RADDR_W-1:0] exm_rd_addr,
  input  logic               exm_rd_we,
  input  logic [XLEN-1:0]    exm_result,
  input  logic [RADDR_W-1:0] mwb_rd_addr,
  input  logic               mwb_rd_we,
  input  logic [XLEN-1:0]    mwb_result,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [XLEN-1:0]    ex_store_data,
  output logic [XLEN-1:0]    ex_pc,
  output logic [RADDR_W-1:0] ex_rd_addr,
  output logic               ex_rd_we,
  output logic               ex_is_load
);

  typedef enum logic {EMPTY, FULL} occ_t;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] rs1_addr;
    logic [RADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic               a_sel;
    logic               b_sel;
    logic [ALUOP_W-1:0] alu_op;
    logic [RADDR_W-1:0] rd_addr;
    logic               rd_we;
    logic               is_load;
  } id_ex_t;

  occ_t            state;
  id_ex_t          q;
  id_ex_t          d;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;
  logic            luse_stall;
  logic            accept;

  function automatic logic [XLEN-1:0] fwd(
    input logic [RADDR_W-1:0] a,
    input logic [XLEN-1:0]    v
  );
    if (a == '0)
      return v;
    else if (exm_rd_we && exm_rd_addr == a)
      return exm_result;
    else if (mwb_rd_we && mwb_rd_addr == a)
      return mwb_result;
    else
      return v;
  endfunction

  assign fwd1 = fwd(q.rs1_addr, q.rs1_data);
  assign fwd2 = fwd(q.rs2_addr, q.rs2_data);

  assign ex_valid = (state == FULL);

`ifdef HAZARD_DETECT_EN
  // Load result is not yet available to forward; hold decode one cycle.
  assign luse_stall = ex_valid & q.is_load & q.rd_we
                    & (q.rd_addr != '0)
                    & ((q.rd_addr == id_rs1_addr)
                     | (q.rd_addr == id_rs2_addr));
`else
  assign luse_stall = 1'b0;
`endif

  assign id_ready = (!ex_valid | ex_ready) & !luse_stall;
  assign accept   = id_valid & id_ready;

  assign d = '{
    pc:       id_pc,
    rs1_addr: id_rs1_addr,
    rs2_addr: id_rs2_addr,
    rs1_data: id_rs1_data,
    rs2_data: id_rs2_data,
    imm:      id_imm,
    a_sel:    id_a_sel,
    b_sel:    id_b_sel,
    alu_op:   id_alu_op,
    rd_addr:  id_rd_addr,
    rd_we:    id_rd_we,
    is_load:  id_is_load
  };

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      q     <= '0;
    end else begin
      if (flush)
        state <= EMPTY;
      else if (accept)
        state <= FULL;
      else if (ex_ready)
        state <= EMPTY;

      if (accept) begin
        q <= d;
      end else if (ex_valid && !ex_ready) begin
        // Capture forwarded values so a result retiring during the stall survives.
        q.rs1_data <= fwd1;
        q.rs2_data <= fwd2;
      end
    end
  end

  assign ex_a          = q.a_sel ? q.pc : fwd1;
  assign ex_b          = q.b_sel ? q.imm : fwd2;
  assign ex_store_data = fwd2;
  assign ex_alu_op     = q.alu_op;
  assign ex_pc         = q.pc;
  assign ex_rd_addr    = q.rd_addr;
  assign ex_rd_we      = q.rd_we & ex_valid;
  assign ex_is_load    = q.is_load & ex_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed bench for id_ex_stage
// against a queue-based reference model.
module tb_id_ex_stage;

  logic        clk = 0;
  logic        rst = 1;
  logic        flush = 0;
  logic        id_valid = 0;
  logic        id_ready;
  logic [31:0] id_pc = 0;
  logic [4:0]  id_rs1_addr = 0;
  logic [4:0]  id_rs2_addr = 0;
  logic [31:0] id_rs1_data = 0;
  logic [31:0] id_rs2_data = 0;
  logic [31:0] id_imm = 0;
  logic        id_a_sel = 0;
  logic        id_b_sel = 0;
  logic [3:0]  id_alu_op = 0;
  logic [4:0]  id_rd_addr = 0;
  logic        id_rd_we = 0;
  logic        id_is_load = 0;
  logic [4:0]  exm_rd_addr = 0;
  logic        exm_rd_we = 0;
  logic [31:0] exm_result = 0;
  logic [4:0]  mwb_rd_addr = 0;
  logic        mwb_rd_we = 0;
  logic [31:0] mwb_result = 0;
  logic        ex_valid;
  logic        ex_ready = 0;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_store_data;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we;
  logic        ex_is_load;

  int vectors = 0;
  int miscompares = 0;

  id_ex_stage #(.XLEN(32), .RADDR_W(5), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_op(id_alu_op),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we), .id_is_load(id_is_load),
    .exm_rd_addr(exm_rd_addr), .exm_rd_we(exm_rd_we), .exm_result(exm_result),
    .mwb_rd_addr(mwb_rd_addr), .mwb_rd_we(mwb_rd_we), .mwb_result(mwb_result),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we), .ex_is_load(ex_is_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        as, bs, we, ld;
    logic [3:0]  op;
  } ins_t;

  ins_t mq[$];

  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] v);
    if (a == 0) return v;
    if (exm_rd_we && exm_rd_addr == a) return exm_result;
    if (mwb_rd_we && mwb_rd_addr == a) return mwb_result;
    return v;
  endfunction

  function automatic bit stall_m();
`ifdef HAZARD_DETECT_EN
    if (mq.size() != 0 && mq[0].ld && mq[0].we && mq[0].rd != 0 &&
        (mq[0].rd == id_rs1_addr || mq[0].rd == id_rs2_addr))
      return 1;
`endif
    return 0;
  endfunction

  function automatic bit rdy_m();
    return (mq.size() == 0 || ex_ready) && !stall_m();
  endfunction

  always @(posedge clk) begin
    ins_t n;
    bit acc;
    logic [31:0] r1, r2;
    acc = id_valid && rdy_m();
    n.pc = id_pc; n.rs1 = id_rs1_addr; n.rs2 = id_rs2_addr;
    n.rs1d = id_rs1_data; n.rs2d = id_rs2_data; n.imm = id_imm;
    n.as = id_a_sel; n.bs = id_b_sel; n.op = id_alu_op;
    n.rd = id_rd_addr; n.we = id_rd_we; n.ld = id_is_load;
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (mq.size() != 0) begin
        if (ex_ready) begin
          void'(mq.pop_front());
        end else begin
          r1 = fwd(mq[0].rs1, mq[0].rs1d);
          r2 = fwd(mq[0].rs2, mq[0].rs2d);
          mq[0].rs1d = r1;
          mq[0].rs2d = r2;
        end
      end
      if (acc) mq.push_back(n);
    end
  end

  task automatic idle();
    flush = 0; id_valid = 0; id_pc = 0;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_a_sel = 0; id_b_sel = 0; id_alu_op = 0;
    id_rd_addr = 0; id_rd_we = 0; id_is_load = 0;
    exm_rd_addr = 0; exm_rd_we = 0; exm_result = 0;
    mwb_rd_addr = 0; mwb_rd_we = 0; mwb_result = 0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic as, input logic bs, input logic [4:0] rd,
                       input logic we, input logic ld);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    id_a_sel = as; id_b_sel = bs; id_alu_op = pc[5:2];
    id_rd_addr = rd; id_rd_we = we; id_is_load = ld;
  endtask

  task automatic test_reset();
    rst = 1; idle(); ex_ready = 0;
    @(negedge clk); @(negedge clk);
    #1;
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", ex_valid); end
    vectors++; if (ex_a !== 32'h0) begin miscompares++; $display("FAIL reset_a got %h exp 0", ex_a); end
    vectors++; if (ex_b !== 32'h0) begin miscompares++; $display("FAIL reset_b got %h exp 0", ex_b); end
    vectors++; if (ex_store_data !== 32'h0) begin miscompares++; $display("FAIL reset_sd got %h exp 0", ex_store_data); end
    vectors++; if (ex_alu_op !== 4'h0) begin miscompares++; $display("FAIL reset_op got %h exp 0", ex_alu_op); end
    vectors++; if (ex_rd_we !== 1'b0 || ex_is_load !== 1'b0) begin miscompares++; $display("FAIL reset_we_ld got %b%b exp 00", ex_rd_we, ex_is_load); end
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", id_ready); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    idle(); ex_ready = 1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) offer(32'h100 + 32'(4 * c), 1, 2, 0, 0, 0, 1, 1, 9, 1, 0);
      else id_valid = 0;
      #1;
      if (c < 4) begin
        vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready c=%0d got %b exp 1", c, id_ready); end
      end
      if (c >= 1 && c <= 4) begin
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid c=%0d got %b exp 1", c, ex_valid); end
        vectors++; if (ex_pc !== 32'h100 + 32'(4 * (c - 1))) begin miscompares++; $display("FAIL b2b_pc c=%0d got %h exp %h", c, ex_pc, 32'h100 + 32'(4 * (c - 1))); end
        vectors++; if (ex_a !== ex_pc || ex_rd_we !== 1'b1) begin miscompares++; $display("FAIL b2b_a c=%0d got %h exp %h", c, ex_a, 32'h100 + 32'(4 * (c - 1))); end
      end
      if (c == 5) begin
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %b exp 0", ex_valid); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_refresh();
    idle(); ex_ready = 0;
    offer(32'h300, 5, 0, 32'h5, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    idle(); exm_rd_we = 1; exm_rd_addr = 5; exm_result = 32'hAA;
    #1;
    vectors++; if (ex_a !== 32'hAA) begin miscompares++; $display("FAIL refresh_exm got %h exp aa", ex_a); end
    @(negedge clk);
    idle(); mwb_rd_we = 1; mwb_rd_addr = 5; mwb_result = 32'hAA;
    #1;
    vectors++; if (ex_a !== 32'hAA) begin miscompares++; $display("FAIL refresh_mwb got %h exp aa", ex_a); end
    @(negedge clk);
    idle();
    #1;
    vectors++; if (ex_a !== 32'hAA || ex_valid !== 1'b1) begin miscompares++; $display("FAIL refresh_hold got %h v=%b exp aa v=1", ex_a, ex_valid); end
    ex_ready = 1;
    @(negedge clk);
  endtask

  task automatic test_forward();
    idle(); ex_ready = 1;
    offer(32'h400, 0, 3, 0, 32'h33, 0, 0, 0, 1, 1, 0);
    @(negedge clk);
    offer(32'h404, 0, 0, 0, 32'h44, 0, 0, 0, 1, 1, 0);
    exm_rd_we = 1; exm_rd_addr = 3; exm_result = 32'h11;
    mwb_rd_we = 1; mwb_rd_addr = 3; mwb_result = 32'h22;
    #1;
    vectors++; if (ex_b !== 32'h11 || ex_store_data !== 32'h11) begin miscompares++; $display("FAIL fwd_prio got %h/%h exp 11", ex_b, ex_store_data); end
    @(negedge clk);
    offer(32'h408, 0, 3, 0, 32'h33, 32'h77, 0, 1, 1, 1, 0);
    exm_rd_addr = 0; mwb_rd_addr = 0;
    #1;
    vectors++; if (ex_b !== 32'h44 || ex_store_data !== 32'h44) begin miscompares++; $display("FAIL fwd_x0 got %h/%h exp 44", ex_b, ex_store_data); end
    @(negedge clk);
    idle(); mwb_rd_we = 1; mwb_rd_addr = 3; mwb_result = 32'h22;
    #1;
    vectors++; if (ex_b !== 32'h77) begin miscompares++; $display("FAIL fwd_imm got %h exp 77", ex_b); end
    vectors++; if (ex_store_data !== 32'h22) begin miscompares++; $display("FAIL fwd_mwb_sd got %h exp 22", ex_store_data); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    idle(); ex_ready = 1;
    offer(32'hDEAD0, 1, 2, 0, 0, 0, 1, 0, 4, 1, 0);
    flush = 1;
    #1;
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b exp 1", id_ready); end
    @(negedge clk);
    idle();
    #1;
    vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL flush_accept got %b exp 0", ex_valid); end
    offer(32'h500, 1, 2, 0, 0, 0, 1, 0, 4, 1, 0);
    @(negedge clk);
    idle(); ex_ready = 0; flush = 1;
    @(negedge clk);
    idle();
    #1;
    vectors++; if (ex_valid !== 1'b0 || ex_rd_we !== 1'b0) begin miscompares++; $display("FAIL flush_held got %b%b exp 00", ex_valid, ex_rd_we); end
    ex_ready = 1;
    @(negedge clk);
  endtask

  task automatic test_load_use();
    idle(); ex_ready = 1;
    offer(32'h600, 1, 2, 0, 0, 0, 0, 0, 7, 1, 1);
    @(negedge clk);
    offer(32'h604, 7, 2, 0, 0, 0, 1, 0, 8, 1, 0);
    #1;
    vectors++; if (ex_is_load !== 1'b1) begin miscompares++; $display("FAIL lu_isload got %b exp 1", ex_is_load); end
`ifdef HAZARD_DETECT_EN
    vectors++; if (id_ready !== 1'b0) begin miscompares++; $display("FAIL lu_stall got %b exp 0", id_ready); end
    @(negedge clk);
    #1;
    vectors++; if (ex_valid !== 1'b0 || id_ready !== 1'b1) begin miscompares++; $display("FAIL lu_bubble got v=%b r=%b exp v=0 r=1", ex_valid, id_ready); end
`else
    vectors++; if (id_ready !== 1'b1) begin miscompares++; $display("FAIL lu_nostall got %b exp 1", id_ready); end
`endif
    @(negedge clk);
    idle();
    #1;
    vectors++; if (ex_valid !== 1'b1 || ex_pc !== 32'h604) begin miscompares++; $display("FAIL lu_accept got v=%b pc=%h exp v=1 pc=604", ex_valid, ex_pc); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      ins_t m;
      logic e_rdy;
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      id_valid = 1'($urandom_range(0, 1));
      ex_ready = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_imm = $urandom;
      id_rs1_data = $urandom; id_rs2_data = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_a_sel = 1'($urandom_range(0, 1)); id_b_sel = 1'($urandom_range(0, 1));
      id_alu_op = 4'($urandom_range(0, 15));
      id_rd_we = 1'($urandom_range(0, 1)); id_is_load = 1'($urandom_range(0, 1));
      exm_rd_we = 1'($urandom_range(0, 1)); exm_rd_addr = 5'($urandom_range(0, 7)); exm_result = $urandom;
      mwb_rd_we = 1'($urandom_range(0, 1)); mwb_rd_addr = 5'($urandom_range(0, 7)); mwb_result = $urandom;
      #1;
      e_rdy = rdy_m();
      vectors++; if (id_ready !== e_rdy) begin miscompares++; $display("FAIL rnd_ready i=%0d got %b exp %b", i, id_ready, e_rdy); end
      vectors++; if (ex_valid !== (mq.size() != 0)) begin miscompares++; $display("FAIL rnd_valid i=%0d got %b exp %b", i, ex_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        m = mq[0];
        vectors++; if (ex_a !== (m.as ? m.pc : fwd(m.rs1, m.rs1d))) begin miscompares++; $display("FAIL rnd_a i=%0d got %h exp %h", i, ex_a, m.as ? m.pc : fwd(m.rs1, m.rs1d)); end
        vectors++; if (ex_b !== (m.bs ? m.imm : fwd(m.rs2, m.rs2d))) begin miscompares++; $display("FAIL rnd_b i=%0d got %h exp %h", i, ex_b, m.bs ? m.imm : fwd(m.rs2, m.rs2d)); end
        vectors++; if (ex_store_data !== fwd(m.rs2, m.rs2d)) begin miscompares++; $display("FAIL rnd_sd i=%0d got %h exp %h", i, ex_store_data, fwd(m.rs2, m.rs2d)); end
        vectors++; if ({ex_pc, ex_alu_op, ex_rd_addr, ex_rd_we, ex_is_load} !== {m.pc, m.op, m.rd, m.we, m.ld}) begin
          miscompares++; $display("FAIL rnd_ctl i=%0d got %h/%h/%h/%b%b exp %h/%h/%h/%b%b", i, ex_pc, ex_alu_op, ex_rd_addr, ex_rd_we, ex_is_load, m.pc, m.op, m.rd, m.we, m.ld);
        end
      end else begin
        vectors++; if (ex_rd_we !== 1'b0 || ex_is_load !== 1'b0) begin miscompares++; $display("FAIL rnd_gate i=%0d got %b%b exp 00", i, ex_rd_we, ex_is_load); end
      end
      @(negedge clk);
    end
    rst = 0; idle(); ex_ready = 1;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_refresh();
    test_forward();
    test_flush();
    test_load_use();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
